transpose_pingpong_unit: RTL and testbench
==========================================

Name: transpose_pingpong_unit

Overview:
Streaming matrix transpose with a parametrised number of matrix buffers, organised as a ring; with the default NUM_BUF=2 this is ping-pong operation.
- Accepts one full row (MAT_DIM lanes) per input beat and emits one full column per output beat.
- Sustains one beat per cycle on both sides.
- A per-matrix mode selects transpose or bypass.
- Sits between the row-major producer and the column-major consumer in the matrix datapath.

Parameters:
DATA_WIDTH, 16, element width in bits
MAT_DIM, 8, matrix is MAT_DIM x MAT_DIM; must be >= 2
NUM_BUF, 2, number of matrix buffers in the ring; must be >= 2

Ports:
clk  in  1  clock
rstb  in  1  reset, synchronous, active-low
s_valid  in  1  input row valid
s_ready  out  1  input row accepted when s_valid & s_ready
s_data  in  MAT_DIM*DATA_WIDTH  row r; lane c at bits [c*DATA_WIDTH +: DATA_WIDTH]
s_mode  in  1  0=transpose, 1=bypass; sampled on row 0 of each matrix only
m_valid  out  1  output beat valid
m_ready  in  1  output beat consumed when m_valid & m_ready
m_data  out  MAT_DIM*DATA_WIDTH  output beat, same lane packing as s_data
m_last  out  1  high on the final beat (index MAT_DIM-1) of a matrix
m_mode  out  1  mode of the matrix currently draining
occupancy  out  $clog2(NUM_BUF+1)  number of buffers in FULL or DRAINING state

Behaviour:
- Buffer state per slot: EMPTY -> FILLING (row 0 accepted) -> FULL (row MAT_DIM-1 accepted) -> DRAINING (first beat consumed) -> EMPTY (last beat consumed).
- A matrix that is one beat long does not exist, since MAT_DIM >= 2.
- wr_ptr and rd_ptr wrap modulo NUM_BUF.
- wr_row and rd_idx are counters of width $clog2(MAT_DIM) and wrap from MAT_DIM-1 to 0.
- The pointer advances on the beat in which its counter wraps.
- s_ready = slot[wr_ptr] is EMPTY or FILLING. It is derived from registered state only, with no combinational path from m_ready.
- m_valid = slot[rd_ptr] is FULL or DRAINING.
- Transpose output: beat c, lane r = A[r][c], where A[r] is the r-th accepted row.
- Bypass output: beat r = A[r] unchanged.
- m_data = 0 whenever m_valid = 0.
- m_last = m_valid & (rd_idx == MAT_DIM-1).
- Latency: the first beat of a matrix is valid on the cycle after row MAT_DIM-1 is accepted. It is not earlier, even if the ring is otherwise empty.
- A slot freed by the last read becomes EMPTY at that clock edge; s_ready reflects the freed slot on the following cycle.
- With NUM_BUF >= 2 and both sides streaming continuously, s_ready and m_valid stay high indefinitely after the first matrix completes.
- Simultaneous write-complete and read-complete in one cycle: both transitions apply; occupancy is unchanged.
- Ring full (all slots FULL or DRAINING): s_ready = 0 and the s_data/s_mode inputs are ignored.
- m_data, m_mode and m_last hold stable while m_valid & ~m_ready.
- Matrices drain strictly in arrival order.
- s_mode is ignored on rows 1..MAT_DIM-1; the latched mode is stored per slot.
- Reset behaviour (synchronous; applies both at power-up and mid-operation):
  - While rstb = 0: s_ready = 0, m_valid = 0, m_last = 0, m_mode = 0, m_data = 0, occupancy = 0.
  - All slots go to EMPTY; pointers and counters go to 0; any partial or undrained matrix is discarded.
  - Storage arrays are not reset.
  - From the first cycle with rstb = 1: s_ready = 1.

Decomposition:
Package transpose_pkg contains:
- buf_state_e (EMPTY, FILLING, FULL, DRAINING)
- mode_e (MODE_TRANSPOSE = 0, MODE_BYPASS = 1)
- function lane_sel(vec, idx), which returns the DATA_WIDTH slice at index idx

Sub-module transpose_buf_bank, instantiated NUM_BUF times:
- Stores MAT_DIM rows plus the latched mode.
- Write port: row index plus data.
- Read port: index plus mode. It returns row idx in bypass mode, or gathers lane idx of every row into column idx in transpose mode.
- The top level holds the ring control, the per-slot state registers and the output mux selected by rd_ptr.

Test Plan:
- Single transpose: rows with A[r][c] = 16'h00rc, m_ready = 1 -> m_valid first rises the cycle after the 8th accept; beat c lane r = 16'h00rc; m_last only on beat 7; occupancy goes 0 -> 1 -> 0.
- Streaming: 4 matrices back-to-back with s_valid = m_ready = 1 -> 32 rows accepted in 32 consecutive cycles; s_ready never drops; 32 outputs correct and in order.
- Backpressure: m_ready = 0 while sending 3 matrices -> after 16 accepts s_ready = 0 and occupancy = 2; rows 17-24 stall. After m_ready = 1, matrix 0 drains first, s_ready returns one cycle after its last beat, and all 3 matrices are correct.
- Mode mix: transpose, bypass (s_mode = 1 on row 0 only, toggled on later rows), transpose -> middle matrix is output row-identical with m_mode = 1 on all 8 beats; outer two are transposed.
- Mid-operation reset: rstb = 0 for 1 cycle after 5 rows of matrix 1 with matrix 0 half-drained -> m_valid = 0 and occupancy = 0 immediately; the next full matrix is transposed correctly with no stale rows.
- Random: s_valid and m_ready each 50% random over 200 matrices -> scoreboard match, stability of m_data under stall, no accept while ring full.

Source files
------------

// File: rtl/transpose_pkg.sv
// Shared types and helpers for the streaming transpose ring.
package transpose_pkg;

    localparam int PKG_DATA_WIDTH = 16;
    localparam int PKG_MAT_DIM    = 8;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } buf_state_e;

    typedef enum logic {
        MODE_TRANSPOSE = 1'b0,
        MODE_BYPASS    = 1'b1
    } mode_e;

    function automatic logic [PKG_DATA_WIDTH-1:0] lane_sel(
        input logic [PKG_MAT_DIM*PKG_DATA_WIDTH-1:0] vec,
        input int unsigned                           idx
    );
        return PKG_DATA_WIDTH'(vec >> (idx * PKG_DATA_WIDTH));
    endfunction

endpackage

// File: rtl/transpose_buf_bank.sv
// One matrix buffer: MAT_DIM stored rows plus the mode latched on row 0.
// Reads return a row (bypass) or a gathered column (transpose).
module transpose_buf_bank
    import transpose_pkg::*;
#(
    parameter int  DATA_WIDTH = PKG_DATA_WIDTH,
    parameter int  MAT_DIM    = PKG_MAT_DIM,
    localparam int IW         = $clog2(MAT_DIM),
    localparam int VW         = MAT_DIM * DATA_WIDTH
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [IW-1:0] wr_row_i,
    input  logic [VW-1:0] wr_data_i,
    input  logic          mode_we_i,
    input  logic          mode_i,
    input  logic [IW-1:0] rd_idx_i,
    output logic [VW-1:0] rd_data_o,
    output logic          rd_mode_o
);

    logic [VW-1:0] rows_q [MAT_DIM];
    mode_e         mode_q;

    // Storage is intentionally not reset; occupancy state in the top guards it.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            rows_q[wr_row_i] <= wr_data_i;
        end
        if (mode_we_i) begin
            mode_q <= mode_e'(mode_i);
        end
    end

    always_comb begin
        rd_data_o = '0;
        if (mode_q == MODE_BYPASS) begin
            rd_data_o = rows_q[rd_idx_i];
        end else begin
            for (int r = 0; r < MAT_DIM; r++) begin
                rd_data_o[r*DATA_WIDTH +: DATA_WIDTH] = lane_sel(rows_q[r], 32'(rd_idx_i));
            end
        end
    end

    assign rd_mode_o = mode_q;

endmodule

// File: rtl/transpose_pingpong_unit.sv
// Ring of NUM_BUF matrix buffers: rows in, columns (or rows in bypass) out.
// state | meaning
// EMPTY    | slot free, may accept row 0
// FILLING  | rows 0..MAT_DIM-2 accepted
// FULL     | all rows stored, waiting for first output beat
// DRAINING | first beat consumed, remaining beats pending
module transpose_pingpong_unit
    import transpose_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int MAT_DIM    = 8,
    parameter int NUM_BUF    = 2
) (
    input  logic                          clk,
    input  logic                          rstb,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [MAT_DIM*DATA_WIDTH-1:0] s_data,
    input  logic                          s_mode,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [MAT_DIM*DATA_WIDTH-1:0] m_data,
    output logic                          m_last,
    output logic                          m_mode,
    output logic [$clog2(NUM_BUF+1)-1:0]  occupancy
);

    localparam int IW = $clog2(MAT_DIM);
    localparam int PW = $clog2(NUM_BUF);
    localparam int OW = $clog2(NUM_BUF + 1);
    localparam int VW = MAT_DIM * DATA_WIDTH;
    localparam logic [IW-1:0] IDX_LAST = IW'(MAT_DIM - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(NUM_BUF - 1);

    buf_state_e    state_q [NUM_BUF];
    buf_state_e    state_d [NUM_BUF];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [IW-1:0] wr_row_q, wr_row_d, rd_idx_q, rd_idx_d;
    logic [VW-1:0] bank_data [NUM_BUF];
    logic          bank_mode [NUM_BUF];
    logic          wr_fire, rd_fire;

    // Handshakes come from registered slot state only; rstb gates them off during reset.
    assign s_ready = rstb && (state_q[wr_ptr_q] == EMPTY || state_q[wr_ptr_q] == FILLING);
    assign m_valid = rstb && (state_q[rd_ptr_q] == FULL || state_q[rd_ptr_q] == DRAINING);
    assign wr_fire = s_valid && s_ready;
    assign rd_fire = m_valid && m_ready;

    assign m_data = m_valid ? bank_data[rd_ptr_q] : '0;
    assign m_mode = m_valid && bank_mode[rd_ptr_q];
    assign m_last = m_valid && (rd_idx_q == IDX_LAST);

    for (genvar i = 0; i < NUM_BUF; i++) begin : g_bank
        transpose_buf_bank #(
            .DATA_WIDTH(DATA_WIDTH),
            .MAT_DIM   (MAT_DIM)
        ) u_bank (
            .clk      (clk),
            .wr_en_i  (wr_fire && (wr_ptr_q == PW'(i))),
            .wr_row_i (wr_row_q),
            .wr_data_i(s_data),
            .mode_we_i(wr_fire && (wr_ptr_q == PW'(i)) && (wr_row_q == '0)),
            .mode_i   (s_mode),
            .rd_idx_i (rd_idx_q),
            .rd_data_o(bank_data[i]),
            .rd_mode_o(bank_mode[i])
        );
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        wr_row_d = wr_row_q;
        rd_idx_d = rd_idx_q;
        if (wr_fire) begin
            wr_row_d = (wr_row_q == IDX_LAST) ? '0 : wr_row_q + 1'b1;
            if (wr_row_q == '0) begin
                state_d[wr_ptr_q] = FILLING;
            end
            if (wr_row_q == IDX_LAST) begin
                state_d[wr_ptr_q] = FULL;
                wr_ptr_d          = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            end
        end
        // Write and read slots never coincide, so both updates can apply together.
        if (rd_fire) begin
            rd_idx_d = (rd_idx_q == IDX_LAST) ? '0 : rd_idx_q + 1'b1;
            if (rd_idx_q == '0) begin
                state_d[rd_ptr_q] = DRAINING;
            end
            if (rd_idx_q == IDX_LAST) begin
                state_d[rd_ptr_q] = EMPTY;
                rd_ptr_d          = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            for (int i = 0; i < NUM_BUF; i++) begin
                state_q[i] <= EMPTY;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            wr_row_q <= '0;
            rd_idx_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_row_q <= wr_row_d;
            rd_idx_q <= rd_idx_d;
        end
    end

    always_comb begin
        occupancy = '0;
        if (rstb) begin
            for (int i = 0; i < NUM_BUF; i++) begin
                if (state_q[i] == FULL || state_q[i] == DRAINING) begin
                    occupancy = occupancy + OW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_transpose_pingpong_unit.sv
// Bench for transpose_pingpong_unit: queue-based matrix model checked every cycle.
module tb_transpose_pingpong_unit;

    localparam int DW = 16;
    localparam int MD = 8;
    localparam int NB = 2;
    localparam int W  = MD * DW;

    typedef struct {
        logic [W-1:0] data;
        logic         mode;
    } row_t;

    typedef struct {
        logic [W-1:0] data;
        logic         mode;
        logic         last;
    } beat_t;

    logic         clk = 1'b0;
    logic         rstb = 1'b0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [W-1:0] s_data = '0;
    logic         s_mode = 1'b0;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic [W-1:0] m_data;
    logic         m_last;
    logic         m_mode;
    logic [1:0]   occupancy;

    transpose_pingpong_unit #(
        .DATA_WIDTH(DW),
        .MAT_DIM   (MD),
        .NUM_BUF   (NB)
    ) dut (
        .clk      (clk),
        .rstb     (rstb),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_mode   (s_mode),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last),
        .m_mode   (m_mode),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    int    n_cmp = 0, n_bad = 0;
    int    cyc = 0, acc_cnt = 0, nf = 0;
    int    p_sv = 0, p_mr = 0, first_mv_cyc = -1;
    bit    mon_en = 1'b0, s_fire_n = 1'b0;
    row_t  tx_q[$], part_q[$];
    beat_t exp_q[$], cap_q[$];
    int    acc_cyc_q[$];
    beat_t bt;
    row_t  rw;
    logic [W-1:0] last_rows [MD];
    logic [W-1:0] mid_rows  [MD];

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: a completed matrix becomes MD expected beats; slots in use = matrices with beats left.
    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            nf = (exp_q.size() + MD - 1) / MD;
            check("s_ready", s_ready, rstb && nf < NB);
            check("m_valid", m_valid, rstb && exp_q.size() > 0);
            check("occupancy", occupancy, rstb ? nf : 0);
            if (rstb && exp_q.size() > 0) begin
                check("m_data", m_data, exp_q[0].data);
                check("m_last", m_last, exp_q[0].last);
                check("m_mode", m_mode, exp_q[0].mode);
            end else begin
                check("m_data_idle", m_data, '0);
                check("m_last_idle", m_last, 1'b0);
                check("m_mode_idle", m_mode, 1'b0);
            end
            if (m_valid && first_mv_cyc < 0) first_mv_cyc = cyc;
            if (!rstb) begin
                exp_q.delete();
                part_q.delete();
                s_fire_n = 1'b0;
            end else begin
                if (m_valid && m_ready) begin
                    bt.data = m_data;
                    bt.mode = m_mode;
                    bt.last = m_last;
                    cap_q.push_back(bt);
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
                s_fire_n = s_valid && s_ready;
                if (s_fire_n) begin
                    acc_cnt++;
                    acc_cyc_q.push_back(cyc);
                    rw.data = s_data;
                    rw.mode = (part_q.size() == 0) ? s_mode : part_q[0].mode;
                    part_q.push_back(rw);
                    if (part_q.size() == MD) begin
                        for (int b = 0; b < MD; b++) begin
                            bt.mode = part_q[0].mode;
                            bt.last = (b == MD - 1);
                            if (part_q[0].mode) begin
                                bt.data = part_q[b].data;
                            end else begin
                                for (int r = 0; r < MD; r++)
                                    bt.data[r*DW +: DW] = part_q[r].data[b*DW +: DW];
                            end
                            exp_q.push_back(bt);
                        end
                        part_q.delete();
                    end
                end
            end
        end
    end

    // Driver: presents the head of tx_q with probability p_sv, m_ready with probability p_mr.
    initial forever begin
        @(posedge clk);
        #1;
        if (s_fire_n && tx_q.size() > 0) void'(tx_q.pop_front());
        if (tx_q.size() > 0 && $urandom_range(99) < p_sv) begin
            s_valid = 1'b1;
            s_data  = tx_q[0].data;
            s_mode  = tx_q[0].mode;
        end else begin
            s_valid = 1'b0;
            s_data  = {4{$urandom}};
            s_mode  = 1'($urandom);
        end
        m_ready = ($urandom_range(99) < p_mr);
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // kind 0: A[r][c] = 16'h00rc; kind 1: random data, later rows carry ~md; kind 2: random everything
    task automatic push_mat(input bit md, input int kind);
        row_t r;
        for (int i = 0; i < MD; i++) begin
            for (int c = 0; c < MD; c++)
                r.data[c*DW +: DW] = (kind == 0) ? DW'(i * 16 + c) : DW'($urandom);
            r.mode       = (i == 0) ? md : ((kind == 2) ? 1'($urandom) : ~md);
            last_rows[i] = r.data;
            tx_q.push_back(r);
        end
    endtask

    task automatic wait_drain(input int budget, input string nm);
        int n = 0;
        while ((tx_q.size() > 0 || exp_q.size() > 0 || part_q.size() > 0) && n < budget) begin
            cycles(1);
            n++;
        end
        n_cmp++;
        if (n >= budget) begin
            n_bad++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required idle", nm, budget);
        end
    endtask

    int base, cb, c0, n;

    initial begin
        cycles(2);
        mon_en = 1'b1;
        cycles(1);
        rstb = 1'b0;
        cycles(1);
        rstb = 1'b1;
        #1;
        check("reset_sready", s_ready, 1'b1);
        check("reset_occ", occupancy, 2'd0);

        // single transpose with pattern data
        p_sv = 100; p_mr = 100;
        first_mv_cyc = -1;
        base = acc_cnt; cb = cap_q.size();
        push_mat(1'b0, 0);
        wait_drain(200, "single");
        check("single_beats", cap_q.size() - cb, 8);
        check("single_latency", first_mv_cyc - acc_cyc_q[base + 7], 1);
        check("t_b0_l3", cap_q[cb + 0].data[3*DW +: DW], 16'h0030);
        check("t_b5_l2", cap_q[cb + 5].data[2*DW +: DW], 16'h0025);
        check("t_b7_l6", cap_q[cb + 7].data[6*DW +: DW], 16'h0067);
        check("t_b7_last", cap_q[cb + 7].last, 1'b1);
        check("t_b6_last", cap_q[cb + 6].last, 1'b0);

        // back-to-back streaming
        base = acc_cnt; cb = cap_q.size();
        for (int k = 0; k < 4; k++) push_mat(1'($urandom), 1);
        wait_drain(300, "stream");
        check("stream_span", acc_cyc_q[base + 31] - acc_cyc_q[base], 31);
        check("stream_beats", cap_q.size() - cb, 32);

        // backpressure: ring fills after two matrices
        p_mr = 0;
        base = acc_cnt; cb = cap_q.size();
        for (int k = 0; k < 3; k++) push_mat(1'b0, 1);
        cycles(30);
        check("bp_accepts", acc_cnt - base, 16);
        check("bp_sready", s_ready, 1'b0);
        check("bp_occ", occupancy, 2'd2);
        p_mr = 100;
        wait_drain(300, "bp");
        check("bp_beats", cap_q.size() - cb, 24);

        // mode mix: transpose, bypass, transpose
        cb = cap_q.size();
        push_mat(1'b0, 1);
        push_mat(1'b1, 1);
        for (int i = 0; i < MD; i++) mid_rows[i] = last_rows[i];
        push_mat(1'b0, 1);
        wait_drain(300, "mix");
        check("mix_byp_b2", cap_q[cb + 10].data, mid_rows[2]);
        check("mix_byp_b5_mode", cap_q[cb + 13].mode, 1'b1);
        check("mix_tr_mode", cap_q[cb + 3].mode, 1'b0);
        check("mix_tr3_mode", cap_q[cb + 20].mode, 1'b0);

        // mid-operation reset with one matrix part-drained and another part-filled
        p_mr = 0;
        base = acc_cnt;
        push_mat(1'b0, 1);
        push_mat(1'b0, 1);
        for (int i = 0; i < 3; i++) void'(tx_q.pop_back());
        n = 0;
        while (acc_cnt < base + 13 && n < 100) begin cycles(1); n++; end
        check("rst_fill", acc_cnt - base, 13);
        c0 = cap_q.size();
        p_mr = 100;
        n = 0;
        while (cap_q.size() < c0 + 4 && n < 100) begin cycles(1); n++; end
        p_mr = 0;
        cycles(1);
        tx_q.delete();
        rstb = 1'b0;
        #1;
        check("rst_mvalid", m_valid, 1'b0);
        check("rst_occ", occupancy, 2'd0);
        check("rst_sready", s_ready, 1'b0);
        cycles(1);
        rstb = 1'b1;
        #1;
        check("post_rst_sready", s_ready, 1'b1);
        p_mr = 100;
        cb = cap_q.size();
        push_mat(1'b0, 0);
        wait_drain(200, "post_rst");
        check("post_rst_beats", cap_q.size() - cb, 8);
        check("post_rst_b1_l0", cap_q[cb + 1].data[0 +: DW], 16'h0001);
        check("post_rst_b4_l7", cap_q[cb + 4].data[7*DW +: DW], 16'h0074);

        // random traffic
        p_sv = 50; p_mr = 50;
        cb = cap_q.size();
        for (int k = 0; k < 200; k++) push_mat(1'($urandom), 2);
        wait_drain(20000, "random");
        check("random_beats", cap_q.size() - cb, 1600);

        cycles(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
